// File: rtl/capture_pkg.sv
// Shared state/mode encodings and default widths for the capture sequencer.
package capture_pkg;

    localparam int FRAME_W_DEF   = 16;
    localparam int TIMEOUT_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_CFG   = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_FRAME      = 3'd3,
        ST_END        = 3'd4
    } state_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_SNAP = 1'b1
    } mode_e;

    // The watchdog only runs while the capture stage is armed.
    function automatic logic is_capturing(input state_e s);
        return (s == ST_WAIT_FRAME) || (s == ST_FRAME);
    endfunction

endpackage

// File: rtl/capture_watchdog.sv
// Frame watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYC-1.
module capture_watchdog #(
    parameter int                   TIMEOUT_W   = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(1000000)
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_CYC - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Checked against the registered count so expiry wins over an edge seen in the same cycle.
    assign expire_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: turns run/stop/snapshot commands into frame-aligned
// start/end pulses for the capture stage, counts frames and aborts on a watchdog.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int                   FRAME_W     = FRAME_W_DEF,
    parameter int                   TIMEOUT_W   = TIMEOUT_W_DEF,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(1000000)
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCFG_DONE,
    input  logic               iCMD_RUN,
    input  logic               iCMD_STOP,
    input  logic               iCMD_SNAP,
    input  logic [FRAME_W-1:0] iSNAP_N,
    input  logic               iFVAL,
    output logic               oSTART,
    output logic               oEND,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oTIMEOUT,
    output logic [FRAME_W-1:0] oFRAMES,
    output logic [2:0]         oSTATE
);

    state_e             state_q;
    mode_e              mode_q;
    logic               fval_prev_q;
    logic               stop_pending_q;
    logic [FRAME_W-1:0] snap_n_q;
    logic [FRAME_W-1:0] frames_q;
    logic               start_q;
    logic               end_q;
    logic               done_q;
    logic               busy_q;
    logic               timeout_q;

    logic               fall;
    logic               rise;
    logic               capturing;
    logic               wd_expire;
    logic               abort_req;
    logic               snap_ok;
    logic               accept;
    logic               last_frame;
    logic [FRAME_W-1:0] frames_inc;

    assign fall       = fval_prev_q & ~iFVAL;
    assign rise       = ~fval_prev_q & iFVAL;
    assign capturing  = is_capturing(state_q);
    assign abort_req  = iCMD_STOP | ~iCFG_DONE;
    assign snap_ok    = iCMD_SNAP & (|iSNAP_N);
    assign accept     = ~iCMD_STOP & (snap_ok | iCMD_RUN);
    assign frames_inc = (&frames_q) ? frames_q : frames_q + FRAME_W'(1);
    // A stop seen together with the closing rise still ends on this frame.
    assign last_frame = stop_pending_q | abort_req |
                        ((mode_q == MODE_SNAP) && (frames_inc == snap_n_q));

    capture_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .clear_i  (~capturing | fall | rise),
        .enable_i (capturing),
        .expire_o (wd_expire)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_RUN;
            fval_prev_q    <= 1'b0;
            stop_pending_q <= 1'b0;
            snap_n_q       <= '0;
            frames_q       <= '0;
            start_q        <= 1'b0;
            end_q          <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            fval_prev_q <= iFVAL;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q         <= snap_ok ? MODE_SNAP : MODE_RUN;
                        snap_n_q       <= iSNAP_N;
                        frames_q       <= '0;
                        timeout_q      <= 1'b0;
                        stop_pending_q <= 1'b0;
                        busy_q         <= 1'b1;
                        if (iCFG_DONE) begin
                            state_q <= ST_WAIT_FRAME;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_CFG;
                        end
                    end
                end
                ST_WAIT_CFG: begin
                    // Capture was never armed, so no end pulse is owed.
                    if (iCMD_STOP) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (iCFG_DONE) begin
                        state_q <= ST_WAIT_FRAME;
                        start_q <= 1'b1;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_END;
                        end_q     <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (abort_req) begin
                        state_q <= ST_END;
                        end_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (fall && !start_q) begin
                        state_q <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (wd_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_END;
                        end_q     <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (rise) begin
                        frames_q <= frames_inc;
                        if (last_frame) begin
                            state_q <= ST_END;
                            end_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_FRAME;
                        end
                    end else if (abort_req) begin
                        stop_pending_q <= 1'b1;
                    end
                end
                ST_END: begin
                    state_q        <= ST_IDLE;
                    busy_q         <= 1'b0;
                    stop_pending_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oSTART   = start_q;
    assign oEND     = end_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;
    assign oTIMEOUT = timeout_q;
    assign oFRAMES  = frames_q;
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: IDLE command table, hand-built frame sequences
// and randomized frame trains checked against a frame/interval reference model.
module tb_capture_sequencer;

    localparam int MAXC = 256;

    logic        iCLK      = 1'b0;
    logic        iRST      = 1'b0;
    logic        iCFG_DONE = 1'b1;
    logic        iCMD_RUN  = 1'b0;
    logic        iCMD_STOP = 1'b0;
    logic        iCMD_SNAP = 1'b0;
    logic [15:0] iSNAP_N   = '0;
    logic        iFVAL     = 1'b1;
    logic        oSTART, oEND, oBUSY, oDONE, oTIMEOUT;
    logic [15:0] oFRAMES;
    logic [2:0]  oSTATE;

    int vectors     = 0;
    int miscompares = 0;

    capture_sequencer #(
        .FRAME_W     (16),
        .TIMEOUT_W   (24),
        .TIMEOUT_CYC (24'd64)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iCFG_DONE (iCFG_DONE),
        .iCMD_RUN  (iCMD_RUN),
        .iCMD_STOP (iCMD_STOP),
        .iCMD_SNAP (iCMD_SNAP),
        .iSNAP_N   (iSNAP_N),
        .iFVAL     (iFVAL),
        .oSTART    (oSTART),
        .oEND      (oEND),
        .oBUSY     (oBUSY),
        .oDONE     (oDONE),
        .oTIMEOUT  (oTIMEOUT),
        .oFRAMES   (oFRAMES),
        .oSTATE    (oSTATE)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        run;
        logic        stop;
        logic        snap;
        logic [15:0] n;
        logic        cfg;
        logic [5:0]  exp;   // {busy, state[2:0], start, done}
    } vec_t;

    vec_t tbl[8];

    // Per-cycle stimulus and observed outputs for one scenario.
    logic        fv_a[MAXC], run_a[MAXC], stop_a[MAXC], snap_a[MAXC], cfg_a[MAXC];
    logic [15:0] n_a[MAXC];
    logic        st_o[MAXC], en_o[MAXC], dn_o[MAXC], bz_o[MAXC], to_o[MAXC];
    logic [15:0] fr_o[MAXC];
    logic [2:0]  ss_o[MAXC];
    int          len;
    int          fall_c[8], rise_c[8];
    int          nfr;

    function automatic vec_t mk(input logic run, input logic stop, input logic snap,
                                input logic [15:0] n, input logic cfg,
                                input logic busy, input logic [2:0] st, input logic start);
        vec_t v;
        v.run  = run;
        v.stop = stop;
        v.snap = snap;
        v.n    = n;
        v.cfg  = cfg;
        v.exp  = {busy, st, start, 1'b0};
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stim(input int n);
        len = n;
        nfr = 0;
        for (int i = 0; i < MAXC; i++) begin
            fv_a[i] = 1'b1; run_a[i] = 1'b0; stop_a[i] = 1'b0;
            snap_a[i] = 1'b0; cfg_a[i] = 1'b1; n_a[i] = '0;
        end
    endtask

    // Low phase starting at pos: a fall at pos and a rise at pos+lo.
    task automatic add_frame(input int pos, input int lo);
        fall_c[nfr] = pos;
        rise_c[nfr] = pos + lo;
        for (int i = pos; i < pos + lo; i++) fv_a[i] = 1'b0;
        nfr++;
    endtask

    task automatic run_stim();
        for (int i = 0; i < len; i++) begin
            @(posedge iCLK); #1;
            iFVAL = fv_a[i]; iCMD_RUN = run_a[i]; iCMD_STOP = stop_a[i];
            iCMD_SNAP = snap_a[i]; iSNAP_N = n_a[i]; iCFG_DONE = cfg_a[i];
            @(negedge iCLK);
            st_o[i] = oSTART; en_o[i] = oEND; dn_o[i] = oDONE; bz_o[i] = oBUSY;
            to_o[i] = oTIMEOUT; fr_o[i] = oFRAMES; ss_o[i] = oSTATE;
        end
        iCMD_RUN = 1'b0; iCMD_STOP = 1'b0; iCMD_SNAP = 1'b0; iSNAP_N = '0;
    endtask

    // Expected cycles are indices into the observation arrays; -1 means "never".
    task automatic check_run(input string tag, input int exp_start, input int exp_end,
                             input int exp_done, input int exp_frames, input int exp_to);
        int nst = 0, nen = 0, ndn = 0, fst = -1, fen = -1, fdn = -1;
        for (int i = 0; i < len; i++) begin
            if (st_o[i]) begin nst++; if (fst < 0) fst = i; end
            if (en_o[i]) begin nen++; if (fen < 0) fen = i; end
            if (dn_o[i]) begin ndn++; if (fdn < 0) fdn = i; end
        end
        check({tag, "_start_count"}, nst, (exp_start < 0) ? 0 : 1);
        check({tag, "_start_cycle"}, fst, exp_start);
        check({tag, "_end_count"}, nen, (exp_end < 0) ? 0 : 1);
        check({tag, "_end_cycle"}, fen, exp_end);
        check({tag, "_done_count"}, ndn, 1);
        check({tag, "_done_cycle"}, fdn, exp_done);
        if (exp_done >= 0 && exp_done < len) begin
            check({tag, "_frames"}, fr_o[exp_done], exp_frames);
            check({tag, "_timeout"}, to_o[exp_done], exp_to);
        end
        check({tag, "_busy_after"}, bz_o[len-1], 0);
        $display("scenario %s: start@%0d end@%0d done@%0d frames=%0d timeout=%0d",
                 tag, exp_start, exp_end, exp_done, exp_frames, exp_to);
    endtask

    // oFRAMES must step to k the cycle after the k-th counted rise.
    task automatic check_steps(input string tag, input int off, input int n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s_step%0d", tag, k + 1), fr_o[rise_c[off+k] + 1], k + 1);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST = 1'b0; iFVAL = 1'b1; iCFG_DONE = 1'b1;
        iCMD_RUN = 1'b0; iCMD_STOP = 1'b0; iCMD_SNAP = 1'b0; iSNAP_N = '0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
    endtask

    // Random frame train; expectations come from the fall/rise interval list.
    task automatic random_scenario(input int t);
        int s, pos, off, nsnap, ts, exp_end, exp_fr, lo, hi;
        string tag;
        clear_stim(0);
        s   = 3;
        pos = s + int'($urandom_range(0, 5));
        for (int k = 0; k < 6; k++) begin
            lo = int'($urandom_range(2, 15));
            hi = int'($urandom_range(2, 15));
            add_frame(pos, lo);
            pos += lo + hi;
        end
        len = pos + 8;
        off = (fall_c[0] == s) ? 1 : 0;   // a fall in the start cycle is not a frame
        if ($urandom_range(0, 1) == 1) begin
            nsnap     = int'($urandom_range(1, 4));
            snap_a[2] = 1'b1;
            n_a[2]    = 16'(nsnap);
            exp_fr    = nsnap;
            exp_end   = rise_c[off+nsnap-1] + 1;
            tag       = $sformatf("rand%0d_snap%0d", t, nsnap);
        end else begin
            run_a[2] = 1'b1;
            do ts = int'($urandom_range(s, rise_c[off+2]));
            while (ts == fall_c[off] || ts == fall_c[off+1] || ts == fall_c[off+2]);
            stop_a[ts] = 1'b1;
            exp_fr  = 0;
            exp_end = ts + 1;
            for (int k = 0; k < 3; k++)
                if (rise_c[off+k] < ts) exp_fr = k + 1;
            for (int k = 0; k < 3; k++)
                if (ts > fall_c[off+k] && ts <= rise_c[off+k]) begin
                    exp_fr  = k + 1;
                    exp_end = rise_c[off+k] + 1;
                end
            tag = $sformatf("rand%0d_run_stop@%0d", t, ts);
        end
        run_stim();
        check_run(tag, s, exp_end, exp_end, exp_fr, 0);
        check_steps(tag, off, exp_fr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        int hits;

        // IDLE command table: one cycle of inputs, outputs checked the next cycle.
        tbl[0] = mk(0, 0, 0, 16'd0, 1, 0, 3'd0, 0);
        tbl[1] = mk(1, 1, 0, 16'd0, 1, 0, 3'd0, 0);
        tbl[2] = mk(0, 0, 1, 16'd0, 1, 0, 3'd0, 0);
        tbl[3] = mk(0, 1, 1, 16'd5, 1, 0, 3'd0, 0);
        tbl[4] = mk(1, 0, 0, 16'd0, 1, 1, 3'd2, 1);
        tbl[5] = mk(0, 0, 1, 16'd2, 0, 1, 3'd1, 0);
        tbl[6] = mk(1, 0, 0, 16'd0, 0, 1, 3'd1, 0);
        tbl[7] = mk(1, 0, 1, 16'd0, 1, 1, 3'd2, 1);

        for (int r = 0; r < 8; r++) begin
            logic [5:0] got;
            @(negedge iCLK);
            iRST = 1'b0; iFVAL = 1'b1;
            #1;
            check($sformatf("row%0d_reset_outputs", r),
                  {oSTART, oEND, oBUSY, oDONE, oTIMEOUT, oFRAMES, oSTATE}, 0);
            @(negedge iCLK);
            iRST = 1'b1;
            @(posedge iCLK); #1;
            iCMD_RUN = tbl[r].run; iCMD_STOP = tbl[r].stop; iCMD_SNAP = tbl[r].snap;
            iSNAP_N = tbl[r].n; iCFG_DONE = tbl[r].cfg;
            @(posedge iCLK); #1;
            iCMD_RUN = 1'b0; iCMD_STOP = 1'b0; iCMD_SNAP = 1'b0; iSNAP_N = '0; iCFG_DONE = 1'b1;
            @(negedge iCLK);
            got = {oBUSY, oSTATE, oSTART, oDONE};
            check($sformatf("row%0d_busy_state_start_done", r), got, tbl[r].exp);
            $display("row %0d: run=%0b stop=%0b snap=%0b n=%0d cfg=%0b -> busy/state/start/done=%b",
                     r, tbl[r].run, tbl[r].stop, tbl[r].snap, tbl[r].n, tbl[r].cfg, got);
        end
        do_reset();

        // Snapshot of 3 frames, 20 low / 10 high.
        clear_stim(100);
        snap_a[2] = 1'b1; n_a[2] = 16'd3;
        add_frame(4, 20); add_frame(34, 20); add_frame(64, 20);
        run_stim();
        check_run("snap3", 3, 85, 85, 3, 0);
        check_steps("snap3", 0, 3);

        // Continuous run, stop 5 cycles into frame 2.
        clear_stim(100);
        run_a[2] = 1'b1; stop_a[39] = 1'b1;
        add_frame(4, 20); add_frame(34, 20); add_frame(64, 20);
        run_stim();
        check_run("run_stop_midframe", 3, 55, 55, 2, 0);
        check_steps("run_stop_midframe", 0, 2);

        // Config gating: start waits for iCFG_DONE.
        clear_stim(14);
        for (int i = 0; i < 6; i++) cfg_a[i] = 1'b0;
        run_a[2] = 1'b1; stop_a[9] = 1'b1;
        run_stim();
        check("cfg_gate_state", ss_o[3], 1);
        check_run("cfg_gate", 7, 10, 10, 0, 0);

        // Stop before configuration completes: done without end.
        clear_stim(10);
        for (int i = 0; i < 10; i++) cfg_a[i] = 1'b0;
        run_a[2] = 1'b1; stop_a[5] = 1'b1;
        run_stim();
        check("cfg_stop_state", ss_o[6], 0);
        check_run("cfg_stop", -1, -1, 6, 0, 0);

        // Watchdog with FVAL stuck high.
        clear_stim(75);
        run_a[2] = 1'b1;
        run_stim();
        check_run("watchdog", 3, 67, 67, 0, 1);

        // Next accepted snapshot clears the sticky timeout.
        clear_stim(20);
        snap_a[2] = 1'b1; n_a[2] = 16'd1;
        add_frame(4, 5);
        run_stim();
        check("timeout_sticky", to_o[2], 1);
        check("timeout_cleared", to_o[3], 0);
        check_run("snap_after_timeout", 3, 10, 10, 1, 0);

        // A fall in the start cycle is not counted.
        clear_stim(40);
        snap_a[2] = 1'b1; n_a[2] = 16'd1;
        add_frame(3, 10); add_frame(20, 10);
        run_stim();
        check("fall_in_start_state", ss_o[14], 2);
        check("fall_in_start_frames", fr_o[14], 0);
        check_run("fall_in_start", 3, 31, 31, 1, 0);

        for (int t = 0; t < 24; t++) random_scenario(t);

        // Asynchronous reset in the middle of a frame.
        clear_stim(10);
        run_a[2] = 1'b1;
        add_frame(4, 20);
        run_stim();
        check("midframe_state", ss_o[9], 3);
        #2;
        iRST = 1'b0;
        #1;
        check("async_reset_outputs", {oSTART, oEND, oBUSY, oDONE, oTIMEOUT, oFRAMES, oSTATE}, 0);
        iFVAL = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            if (oEND || oBUSY || oDONE) hits++;
        end
        check("after_reset_quiet", hits, 0);
        $display("scenario async_reset: outputs cleared, no end pulse");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Controls when the pixel-capture stage runs.
- Accepts run, stop and snapshot commands from the host/key logic.
- Waits for sensor configuration to complete, then issues single-cycle start/end pulses to the capture stage so that exactly whole frames are captured.
- Tracks frame boundaries on the sensor FVAL, counts completed frames and aborts on a frame watchdog timeout.
- Sits between the control/user interface and the capture stage, in the sensor pixel-clock domain.

Parameters:
FRAME_W, 16, width of the snapshot request and completed-frame counter.
TIMEOUT_W, 24, width of the watchdog counter.
TIMEOUT_CYC, 24'd1000000, iCLK cycles without an FVAL edge before abort; must be >= 2.

Ports:
iCLK  in  1  pixel clock; all logic on its rising edge.
iRST  in  1  asynchronous, active-low reset.
iCFG_DONE  in  1  level; sensor register configuration complete.
iCMD_RUN  in  1  pulse; start continuous capture.
iCMD_STOP  in  1  pulse; stop after the current frame.
iCMD_SNAP  in  1  pulse; capture iSNAP_N frames, then stop.
iSNAP_N  in  FRAME_W  frame count, sampled with iCMD_SNAP.
iFVAL  in  1  raw sensor frame-valid, synchronous to iCLK; a falling edge starts a frame and a rising edge ends it.
oSTART  out  1  one-cycle start pulse to the capture stage.
oEND  out  1  one-cycle end pulse to the capture stage.
oBUSY  out  1  high in any state other than IDLE.
oDONE  out  1  one-cycle pulse when a run/snapshot terminates for any reason.
oTIMEOUT  out  1  sticky; last run ended by the watchdog.
oFRAMES  out  FRAME_W  frames completed in the current or last run; saturates at all-ones.
oSTATE  out  3  current state encoding, for debug.

Behaviour:
- Reset: all outputs 0, state IDLE, internal previous-FVAL register 0, counters 0.
- Edge detect: prev <= iFVAL every cycle.
  - fall = prev & ~iFVAL
  - rise = ~prev & iFVAL
- States: IDLE=0, WAIT_CFG=1, WAIT_FRAME=2, FRAME=3, END=4. All outputs are registered.
- IDLE:
  - iCMD_STOP has priority; if asserted, stay in IDLE.
  - Else iCMD_SNAP with iSNAP_N != 0 is accepted; latch N, mode=SNAP.
  - Else iCMD_RUN is accepted; mode=RUN.
  - iCMD_SNAP with iSNAP_N=0 is ignored (no oDONE).
  - On accept: clear oFRAMES and oTIMEOUT. Go to WAIT_FRAME if iCFG_DONE=1, else WAIT_CFG.
- WAIT_CFG:
  - Go to WAIT_FRAME when iCFG_DONE=1.
  - iCMD_STOP goes to IDLE with a oDONE pulse and no oEND; capture was never started.
  - The watchdog is idle in this state.
- Entry into WAIT_FRAME from IDLE/WAIT_CFG: oSTART=1 for exactly the first cycle in the state. A fall in that same cycle is ignored, because the capture stage is not yet armed.
- WAIT_FRAME:
  - fall (with oSTART=0): go to FRAME.
  - iCMD_STOP or iCFG_DONE=0: go to END.
- FRAME, on rise:
  - oFRAMES += 1 (saturating).
  - If a stop is pending, or mode=SNAP and the new count equals N: go to END.
  - Else go back to WAIT_FRAME (no oSTART).
- FRAME, on iCMD_STOP or iCFG_DONE=0: set stop_pending and finish the current frame. It is not truncated.
- Simultaneous iCMD_STOP and rise in FRAME: count the frame, then go to END.
- Watchdog:
  - Counter clears on entry to WAIT_FRAME/FRAME and on every fall/rise. It increments while in WAIT_FRAME or FRAME.
  - When it reaches TIMEOUT_CYC-1: oTIMEOUT <= 1 and go to END. Timeout has priority over an edge in the same cycle.
- END: oEND=1 and oDONE=1 for one cycle; clear stop_pending; go to IDLE.
  - oEND is therefore issued the cycle after the final rise, well before the next fall.
- Commands while oBUSY=1 are ignored, except iCMD_STOP.
- Asynchronous reset mid-run: immediate return to IDLE with no oEND. The capture stage shares iRST and resets too.

Decomposition:
- Package capture_pkg holds:
  - state encoding constants
  - mode constants (RUN=0, SNAP=1)
  - default FRAME_W/TIMEOUT_W
- One natural sub-module: capture_watchdog, containing the counter with clear/enable inputs and a one-cycle expire output.
- Edge detection and the FSM stay in capture_sequencer.

Test Plan:
- Bench setup: TIMEOUT_CYC=64 and iCFG_DONE=1; frames are iFVAL low for 20 cycles, high for 10.
- Snapshot: iCMD_SNAP with iSNAP_N=3 -> one oSTART; oFRAMES steps 1,2,3; oEND and oDONE one cycle after the 3rd rise; no further oSTART; oBUSY low afterwards.
- Continuous with mid-frame stop: iCMD_RUN, then iCMD_STOP 5 cycles into frame 2 -> frame 2 completes; oFRAMES=2; oEND the cycle after its rise.
- Config gating: iCFG_DONE=0, then iCMD_RUN -> oSTATE=1 and no oSTART; raise iCFG_DONE -> oSTART next cycle. Repeat with iCMD_STOP before iCFG_DONE -> oDONE=1, oEND never asserted.
- Watchdog: iCMD_RUN with iFVAL held high -> oTIMEOUT=1 and oEND 64 cycles after the oSTART cycle; oFRAMES=0. A subsequent accepted iCMD_SNAP clears oTIMEOUT.
- Boundary and priority cases:
  - fall in the oSTART cycle -> not counted; capture waits for the next frame.
  - iCMD_RUN together with iCMD_STOP in IDLE -> stays in IDLE.
  - iCMD_SNAP with N=0 -> no response.
  - iRST low during FRAME -> all outputs 0 immediately.
